// File: rtl/seq_load_sequencer_if.sv
// Bundle of the request, AR and per-beat transaction-control channels of seq_load_sequencer.
// Modport master is the sequencer side; slave is the front-end / AXI / load-controller side.
interface seq_load_sequencer_if #(
  parameter int unsigned AxiDataWidth = 64,
  parameter int unsigned AxiAddrWidth = 32,
  parameter int unsigned LenWidth     = 16
);
  localparam int unsigned BusNSize = $clog2(AxiDataWidth / 4);
  localparam int unsigned BeatW    = LenWidth - BusNSize + 1;

  logic                    req_valid_i;
  logic                    req_ready_o;
  logic [AxiAddrWidth:0]   req_addr_i;
  logic [LenWidth-1:0]     req_nbs_i;

  logic                    ar_valid_o;
  logic                    ar_ready_i;
  logic [AxiAddrWidth-1:0] ar_addr_o;
  logic [7:0]              ar_len_o;

  logic                    txn_ctrl_valid_o;
  logic                    txn_ctrl_ready_i;
  logic [AxiAddrWidth:0]   txn_ctrl_addr_o;
  logic                    txn_ctrl_isHead_o;
  logic [BeatW-1:0]        txn_ctrl_rmnBeat_o;
  logic [BusNSize:0]       txn_ctrl_lbN_o;
  logic                    txn_ctrl_isFinalBeat_o;

  modport master (
    input  req_valid_i, req_addr_i, req_nbs_i, ar_ready_i, txn_ctrl_ready_i,
    output req_ready_o, ar_valid_o, ar_addr_o, ar_len_o,
           txn_ctrl_valid_o, txn_ctrl_addr_o, txn_ctrl_isHead_o,
           txn_ctrl_rmnBeat_o, txn_ctrl_lbN_o, txn_ctrl_isFinalBeat_o
  );

  modport slave (
    output req_valid_i, req_addr_i, req_nbs_i, ar_ready_i, txn_ctrl_ready_i,
    input  req_ready_o, ar_valid_o, ar_addr_o, ar_len_o,
           txn_ctrl_valid_o, txn_ctrl_addr_o, txn_ctrl_isHead_o,
           txn_ctrl_rmnBeat_o, txn_ctrl_lbN_o, txn_ctrl_isFinalBeat_o
  );
endinterface

// File: rtl/seq_load_sequencer.sv
// Splits one unit-stride nibble load request into AXI AR bursts and per-beat control records.
// Define SEQ_LOAD_4K_SPLIT_EN to keep every burst inside one 4 KiB page.
module seq_load_sequencer #(
  parameter int unsigned AxiDataWidth  = 64,
  parameter int unsigned AxiAddrWidth  = 32,
  parameter int unsigned LenWidth      = 16,
  parameter int unsigned MaxBurstBeats = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  seq_load_sequencer_if.master bus,
  output logic [1:0]           dbg_state_o
);
  localparam int unsigned BusNibbles = AxiDataWidth / 4;
  localparam int unsigned BusNSize   = $clog2(BusNibbles);
  localparam int unsigned ByteOff    = $clog2(AxiDataWidth / 8);
  localparam int unsigned BeatW      = LenWidth - BusNSize + 1;

  typedef logic [AxiAddrWidth:0]   naddr_t;
  typedef logic [AxiAddrWidth-1:0] baddr_t;
  typedef logic [LenWidth:0]       span_t;
  typedef logic [BeatW-1:0]        beat_t;
  typedef logic [BusNSize:0]       lbn_t;

  // Handshake rule for both output channels: a transfer happens on a rising clk_i edge
  // where valid && ready; valid and payload are held stable from assertion until that
  // edge, and valid is a register output that never looks at ready.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_e;

  state_e state_q, state_d;
  baddr_t ar_addr_q;
  beat_t  ar_rmn_q;
  logic   ar_valid_q;
  naddr_t beat_addr_q;
  beat_t  beat_rmn_q;
  logic   txn_valid_q;
  logic   is_head_q;
  lbn_t   lbn_q;

  logic                accept, ar_hs, txn_hs, ar_last, ar_done_nx, beat_done_nx;
  logic [BusNSize-1:0] off;
  span_t               span, span_m1;
  beat_t               tot_beats;
  lbn_t                lbn_nx;
  baddr_t              ar_start;
  naddr_t              beat_next;
  logic [31:0]         bb;

  assign accept    = (state_q == S_IDLE) && bus.req_valid_i;
  assign off       = bus.req_addr_i[BusNSize-1:0];
  assign span      = {1'b0, bus.req_nbs_i} + span_t'(off);
  assign span_m1   = span - span_t'(1);
  assign tot_beats = beat_t'((span + span_t'(BusNibbles - 1)) >> BusNSize);
  assign lbn_nx    = {1'b0, span_m1[BusNSize-1:0]} + lbn_t'(1);
  assign ar_start  = {bus.req_addr_i[AxiAddrWidth:ByteOff+1], {ByteOff{1'b0}}};
  assign beat_next = {beat_addr_q[AxiAddrWidth:BusNSize], {BusNSize{1'b0}}} + naddr_t'(BusNibbles);

`ifdef SEQ_LOAD_4K_SPLIT_EN
  logic [31:0] page_beats;
  // ar_addr_q is always bus-aligned, so this division is exact.
  assign page_beats = 32'((13'h1000 - {1'b0, ar_addr_q[11:0]}) >> ByteOff);
`endif

  always_comb begin
    bb = 32'(ar_rmn_q);
    if (bb > MaxBurstBeats) bb = MaxBurstBeats;
`ifdef SEQ_LOAD_4K_SPLIT_EN
    if (bb > page_beats) bb = page_beats;
`endif
  end

  assign ar_hs        = ar_valid_q && bus.ar_ready_i;
  assign txn_hs       = txn_valid_q && bus.txn_ctrl_ready_i;
  assign ar_last      = (32'(ar_rmn_q) == bb);
  assign ar_done_nx   = !ar_valid_q || (ar_hs && ar_last);
  assign beat_done_nx = !txn_valid_q || (txn_hs && (beat_rmn_q == '0));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.req_valid_i) state_d = S_RUN;
      S_RUN: begin
        if (ar_done_nx && beat_done_nx) state_d = S_IDLE;
        else if (ar_done_nx)            state_d = S_DRAIN;
      end
      S_DRAIN: if (beat_done_nx) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      ar_addr_q   <= '0;
      ar_rmn_q    <= '0;
      ar_valid_q  <= 1'b0;
      beat_addr_q <= '0;
      beat_rmn_q  <= '0;
      txn_valid_q <= 1'b0;
      is_head_q   <= 1'b0;
      lbn_q       <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ar_addr_q   <= ar_start;
        ar_rmn_q    <= tot_beats;
        ar_valid_q  <= 1'b1;
        beat_addr_q <= bus.req_addr_i;
        beat_rmn_q  <= tot_beats - beat_t'(1);
        txn_valid_q <= 1'b1;
        is_head_q   <= 1'b1;
        lbn_q       <= lbn_nx;
      end else begin
        if (ar_hs) begin
          ar_addr_q <= ar_addr_q + (baddr_t'(bb) << ByteOff);
          ar_rmn_q  <= ar_rmn_q - beat_t'(bb);
          if (ar_last) ar_valid_q <= 1'b0;
        end
        if (txn_hs) begin
          beat_addr_q <= beat_next;
          beat_rmn_q  <= beat_rmn_q - beat_t'(1);
          is_head_q   <= 1'b0;
          if (beat_rmn_q == '0) txn_valid_q <= 1'b0;
        end
      end
    end
  end

  // A zero-length request has no meaningful beat count.
  always_ff @(posedge clk_i) begin
    if (!rst_i && accept) assert (bus.req_nbs_i != '0);
  end

  assign bus.req_ready_o            = (state_q == S_IDLE);
  assign bus.ar_valid_o             = ar_valid_q;
  assign bus.ar_addr_o              = ar_addr_q;
  assign bus.ar_len_o               = ar_valid_q ? 8'(bb - 32'd1) : 8'd0;
  assign bus.txn_ctrl_valid_o       = txn_valid_q;
  assign bus.txn_ctrl_addr_o        = beat_addr_q;
  assign bus.txn_ctrl_isHead_o      = is_head_q;
  assign bus.txn_ctrl_rmnBeat_o     = beat_rmn_q;
  assign bus.txn_ctrl_lbN_o         = lbn_q;
  assign bus.txn_ctrl_isFinalBeat_o = txn_valid_q && (beat_rmn_q == '0);
  assign dbg_state_o                = state_q;
endmodule

// File: tb/tb_seq_load_sequencer.sv
// Directed bench for seq_load_sequencer (AxiDataWidth=64, MaxBurstBeats=16).
// Expected AR bursts and beat records are hand-computed per scenario.
module tb_seq_load_sequencer;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DRAIN = 2'd2;

  typedef struct packed {
    logic [32:0] addr;
    logic        head;
    logic [12:0] rmn;
    logic [4:0]  lbn;
    logic        fin;
  } beat_rec_t;

  logic clk;
  logic rst;
  logic [1:0] dbg_state;
  int total = 0;
  int bad   = 0;

  logic [31:0] ar_a_q[$];
  logic [7:0]  ar_l_q[$];
  beat_rec_t   beat_q[$];
  beat_rec_t   mon_b;

  seq_load_sequencer_if bus ();

  seq_load_sequencer #(
    .AxiDataWidth(64), .AxiAddrWidth(32), .LenWidth(16), .MaxBurstBeats(16)
  ) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus), .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // monitor: inputs change #1 after posedge, so negedge sees the values of the coming edge
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.ar_valid_o && bus.ar_ready_i) begin
        ar_a_q.push_back(bus.ar_addr_o);
        ar_l_q.push_back(bus.ar_len_o);
      end
      if (bus.txn_ctrl_valid_o && bus.txn_ctrl_ready_i) begin
        mon_b.addr = bus.txn_ctrl_addr_o;
        mon_b.head = bus.txn_ctrl_isHead_o;
        mon_b.rmn  = bus.txn_ctrl_rmnBeat_o;
        mon_b.lbn  = bus.txn_ctrl_lbN_o;
        mon_b.fin  = bus.txn_ctrl_isFinalBeat_o;
        beat_q.push_back(mon_b);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    ar_a_q.delete();
    ar_l_q.delete();
    beat_q.delete();
  endtask

  task automatic send(input logic [32:0] a, input logic [15:0] n);
    chk("req_ready_before_send", 64'(bus.req_ready_o), 64'd1);
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = a;
    bus.req_nbs_i   = n;
    step();
    bus.req_valid_i = 1'b0;
    chk("state_after_accept", 64'(dbg_state), 64'(ST_RUN));
    chk("ar_valid_after_accept", 64'(bus.ar_valid_o), 64'd1);
    chk("txn_valid_after_accept", 64'(bus.txn_ctrl_valid_o), 64'd1);
  endtask

  task automatic wait_idle(input string sc, input int budget);
    int n;
    n = 0;
    while (dbg_state != ST_IDLE && n < budget) begin
      step();
      n++;
    end
    chk({sc, "_idle_within_budget"}, 64'(n < budget), 64'd1);
  endtask

  task automatic chk_ar(input string sc, input int i, input logic [31:0] a, input logic [7:0] l);
    logic [31:0] oa;
    logic [7:0]  ol;
    oa = (i < ar_a_q.size()) ? ar_a_q[i] : 32'hFFFF_FFFF;
    ol = (i < ar_l_q.size()) ? ar_l_q[i] : 8'hFF;
    chk($sformatf("%s_ar%0d_addr", sc, i), 64'(oa), 64'(a));
    chk($sformatf("%s_ar%0d_len", sc, i), 64'(ol), 64'(l));
  endtask

  task automatic chk_beat(input string sc, input int i, input logic [32:0] a, input logic h,
                          input logic [12:0] r, input logic f, input logic [4:0] lbn);
    beat_rec_t b;
    b = (i < beat_q.size()) ? beat_q[i] : '1;
    chk($sformatf("%s_beat%0d_addr", sc, i), 64'(b.addr), 64'(a));
    chk($sformatf("%s_beat%0d_head", sc, i), 64'(b.head), 64'(h));
    chk($sformatf("%s_beat%0d_rmn", sc, i), 64'(b.rmn), 64'(r));
    chk($sformatf("%s_beat%0d_final", sc, i), 64'(b.fin), 64'(f));
    if (f) chk($sformatf("%s_beat%0d_lbn", sc, i), 64'(b.lbn), 64'(lbn));
  endtask

  task automatic scenario1(input string sc);
    clear_q();
    send(33'h6, 16'd40);
    wait_idle(sc, 50);
    chk({sc, "_ar_count"}, 64'(ar_a_q.size()), 64'd1);
    chk_ar(sc, 0, 32'h0, 8'd2);
    chk({sc, "_beat_count"}, 64'(beat_q.size()), 64'd3);
    chk_beat(sc, 0, 33'h6,  1'b1, 13'd2, 1'b0, 5'd14);
    chk_beat(sc, 1, 33'h10, 1'b0, 13'd1, 1'b0, 5'd14);
    chk_beat(sc, 2, 33'h20, 1'b0, 13'd0, 1'b1, 5'd14);
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid_i      = 1'b0;
    bus.req_addr_i       = '0;
    bus.req_nbs_i        = '0;
    bus.ar_ready_i       = 1'b1;
    bus.txn_ctrl_ready_i = 1'b1;
    repeat (3) step();

    // reset values
    chk("rst_req_ready", 64'(bus.req_ready_o), 64'd1);
    chk("rst_ar_valid", 64'(bus.ar_valid_o), 64'd0);
    chk("rst_txn_valid", 64'(bus.txn_ctrl_valid_o), 64'd0);
    chk("rst_ar_addr", 64'(bus.ar_addr_o), 64'd0);
    chk("rst_ar_len", 64'(bus.ar_len_o), 64'd0);
    chk("rst_txn_addr", 64'(bus.txn_ctrl_addr_o), 64'd0);
    chk("rst_txn_head", 64'(bus.txn_ctrl_isHead_o), 64'd0);
    chk("rst_txn_rmn", 64'(bus.txn_ctrl_rmnBeat_o), 64'd0);
    chk("rst_txn_lbn", 64'(bus.txn_ctrl_lbN_o), 64'd0);
    chk("rst_txn_final", 64'(bus.txn_ctrl_isFinalBeat_o), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    rst = 1'b0;
    step();

    // 1: offset request
    scenario1("s1");

    // 2: 4 KiB crossing
    clear_q();
    send(33'h1FE0, 16'd64);
    wait_idle("s2", 50);
`ifdef SEQ_LOAD_4K_SPLIT_EN
    chk("s2_ar_count", 64'(ar_a_q.size()), 64'd2);
    chk_ar("s2", 0, 32'hFF0, 8'd1);
    chk_ar("s2", 1, 32'h1000, 8'd1);
`else
    chk("s2_ar_count", 64'(ar_a_q.size()), 64'd1);
    chk_ar("s2", 0, 32'hFF0, 8'd3);
`endif
    chk("s2_beat_count", 64'(beat_q.size()), 64'd4);
    chk_beat("s2", 0, 33'h1FE0, 1'b1, 13'd3, 1'b0, 5'd16);
    chk_beat("s2", 1, 33'h1FF0, 1'b0, 13'd2, 1'b0, 5'd16);
    chk_beat("s2", 2, 33'h2000, 1'b0, 13'd1, 1'b0, 5'd16);
    chk_beat("s2", 3, 33'h2010, 1'b0, 13'd0, 1'b1, 5'd16);

    // 3: max-burst split
    clear_q();
    send(33'h0, 16'd320);
    wait_idle("s3", 100);
    chk("s3_ar_count", 64'(ar_a_q.size()), 64'd2);
    chk_ar("s3", 0, 32'h0, 8'd15);
    chk_ar("s3", 1, 32'h80, 8'd3);
    chk("s3_beat_count", 64'(beat_q.size()), 64'd20);
    for (int i = 0; i < 20; i++)
      chk_beat("s3", i, 33'(i * 16), 1'(i == 0), 13'(19 - i), 1'(i == 19), 5'd16);

    // 4: beat back-pressure while AR proceeds
    clear_q();
    bus.txn_ctrl_ready_i = 1'b0;
    send(33'h6, 16'd40);
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("s4_hold%0d_valid", c), 64'(bus.txn_ctrl_valid_o), 64'd1);
      chk($sformatf("s4_hold%0d_addr", c), 64'(bus.txn_ctrl_addr_o), 64'h6);
      chk($sformatf("s4_hold%0d_head", c), 64'(bus.txn_ctrl_isHead_o), 64'd1);
      chk($sformatf("s4_hold%0d_rmn", c), 64'(bus.txn_ctrl_rmnBeat_o), 64'd2);
      chk($sformatf("s4_hold%0d_state", c), 64'(dbg_state), 64'(ST_DRAIN));
    end
    chk("s4_ar_issued", 64'(ar_a_q.size()), 64'd1);
    chk("s4_ar_valid_low", 64'(bus.ar_valid_o), 64'd0);
    bus.txn_ctrl_ready_i = 1'b1;
    wait_idle("s4", 50);
    chk("s4_beat_count", 64'(beat_q.size()), 64'd3);
    chk_beat("s4", 0, 33'h6,  1'b1, 13'd2, 1'b0, 5'd14);
    chk_beat("s4", 2, 33'h20, 1'b0, 13'd0, 1'b1, 5'd14);

    // 5: single nibble, two-cycle occupancy
    clear_q();
    send(33'hF, 16'd1);
    chk("s5_ar_addr", 64'(bus.ar_addr_o), 64'h0);
    chk("s5_ar_len", 64'(bus.ar_len_o), 64'd0);
    chk("s5_txn_addr", 64'(bus.txn_ctrl_addr_o), 64'hF);
    chk("s5_txn_head", 64'(bus.txn_ctrl_isHead_o), 64'd1);
    chk("s5_txn_final", 64'(bus.txn_ctrl_isFinalBeat_o), 64'd1);
    chk("s5_txn_rmn", 64'(bus.txn_ctrl_rmnBeat_o), 64'd0);
    chk("s5_txn_lbn", 64'(bus.txn_ctrl_lbN_o), 64'd16);
    step();
    chk("s5_state_idle", 64'(dbg_state), 64'(ST_IDLE));
    chk("s5_req_ready", 64'(bus.req_ready_o), 64'd1);
    chk("s5_ar_valid_low", 64'(bus.ar_valid_o), 64'd0);
    chk("s5_txn_valid_low", 64'(bus.txn_ctrl_valid_o), 64'd0);
    chk("s5_ar_count", 64'(ar_a_q.size()), 64'd1);
    chk("s5_beat_count", 64'(beat_q.size()), 64'd1);

    // 6: reset right after accepting a long request
    clear_q();
    send(33'h0, 16'd320);
    rst = 1'b1;
    step();
    chk("s6_ar_valid", 64'(bus.ar_valid_o), 64'd0);
    chk("s6_txn_valid", 64'(bus.txn_ctrl_valid_o), 64'd0);
    chk("s6_req_ready", 64'(bus.req_ready_o), 64'd1);
    chk("s6_state", 64'(dbg_state), 64'(ST_IDLE));
    rst = 1'b0;
    repeat (4) step();
    chk("s6_no_ar_after_reset", 64'(ar_a_q.size()), 64'd0);
    chk("s6_no_beat_after_reset", 64'(beat_q.size()), 64'd0);
    scenario1("s6_fresh");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
